led7seg_scan: RTL

LED7SEG_SCAN -- requirements
Module: led7seg_scan

---
 rtl/led7seg_scan.sv | 54 +++++
 1 files changed

// File: rtl/led7seg_scan.sv
// led7seg_scan: four-digit multiplexed hex scanner with frame-aligned display updates.
// Define LED7SEG_SCAN_BLANK_EN to compile in leading-zero blanking.
module led7seg_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_din,
  output logic [3:0]  o_digit,
  output logic [3:0]  o_sa,
  output logic        o_blank,
  output logic        o_busy
);
  logic [15:0] r_presc;
  logic [1:0]  r_idx;
  logic [15:0] r_disp;
  logic [15:0] r_pend;
  logic        r_busy;
  logic        w_wrap;
  logic        w_frame;
  assign w_wrap  = r_presc == 16'(SCAN_DIV - 1);
  assign w_frame = w_wrap && (r_idx == 2'd3);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_disp  <= '0;
      r_pend  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 16'd1;
      if (w_wrap) r_idx <= r_idx + 2'd1;
      if (w_frame && r_busy) r_disp <= r_pend;
      // a load coinciding with the frame edge keeps busy high for the new value
      if (i_load) begin
        r_pend <= i_din;
        r_busy <= 1'b1;
      end else if (w_frame) begin
        r_busy <= 1'b0;
      end
    end
  end
  assign o_sa    = ~(4'b0001 << r_idx);
  assign o_digit = r_disp[{r_idx, 2'b00} +: 4];
  assign o_busy  = r_busy;
`ifdef LED7SEG_SCAN_BLANK_EN
  assign o_blank = (r_idx == 2'd3) ? ~|r_disp[15:12] :
                   (r_idx == 2'd2) ? ~|r_disp[15:8]  :
                   (r_idx == 2'd1) ? ~|r_disp[15:4]  : 1'b0;
`else
  assign o_blank = 1'b0;
`endif
endmodule
